// File: rtl/rsa_pkg.sv
// Shared widths and the modular-inverse controller state encoding.
package rsa_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned TWIDTH = 33;

  typedef enum logic [2:0] {
    StReset,
    StWait,
    StLoad,
    StDivide,
    StUpdate,
    StFixup,
    StFinished
  } inv_state_e;

endpackage

// File: rtl/divider_sm.sv
// Restoring divider, one quotient bit per cycle. div_done pulses 33 cycles after div_start.
module divider_sm
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_done
);

  logic             busy_q;
  logic [5:0]       cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    fits      = ~diff[WIDTH];
    quotient  = quo_q;
    remainder = rem_q;
    div_done  = busy_q && (cnt_q == 6'd32);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (div_start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      if (cnt_q == 6'd32) begin
        busy_q <= 1'b0;
      end else begin
        quo_q <= {quo_q[WIDTH-2:0], fits};
        // A failed trial subtraction leaves rem_shift below the divisor, so bit 32 is zero.
        rem_q <= fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

endmodule

// File: rtl/mod_inverse.sv
// Extended-Euclid modular inverse d = e^-1 mod phi, one divider pass per iteration.
module mod_inverse
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inv_ready,
  input  logic [WIDTH-1:0] phi,
  input  logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] out,
  output logic             inv_done,
  output logic             inv_err
);

  inv_state_e        state_q, state_d;
  logic [WIDTH-1:0]  phi_q, r0_q, r1_q, out_q;
  logic [TWIDTH-1:0] t0_q, t1_q, t_next, t0_plus_phi;
  logic              err_path_q, err_q, div_sent_q;
  logic              div_start, div_done;
  logic [WIDTH-1:0]  quotient, remainder;

  divider_sm u_divider (
    .clk       (clk),
    .reset_n   (reset_n),
    .div_start (div_start),
    .dividend  (r0_q),
    .divisor   (r1_q),
    .quotient  (quotient),
    .remainder (remainder),
    .div_done  (div_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StReset;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:    state_d = StWait;
      StWait:     if (inv_ready) state_d = StLoad;
      StLoad:     state_d = ((e == '0) || (phi < 32'd2)) ? StFixup : StDivide;
      StDivide:   if (div_done) state_d = StUpdate;
      StUpdate:   state_d = (remainder != '0) ? StDivide : StFixup;
      StFixup:    state_d = StFinished;
      StFinished: if (!inv_ready) state_d = StWait;
      default:    state_d = StReset;
    endcase
  end

  always_comb begin
    div_start = (state_q == StDivide) && !div_sent_q;
    inv_done  = (state_q == StFinished);
    inv_err   = err_q;
    out       = out_q;
  end

  // Bezout coefficients wrap modulo 2^33; exact because |t| never exceeds phi.
  always_comb begin
    t_next      = t0_q - ({1'b0, quotient} * t1_q);
    t0_plus_phi = t0_q + {1'b0, phi_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi_q      <= '0;
      r0_q       <= '0;
      r1_q       <= '0;
      t0_q       <= '0;
      t1_q       <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
      err_path_q <= 1'b0;
      div_sent_q <= 1'b0;
    end else begin
      unique case (state_q)
        StWait: begin
          out_q      <= '0;
          err_q      <= 1'b0;
          div_sent_q <= 1'b0;
        end
        StLoad: begin
          phi_q      <= phi;
          r0_q       <= phi;
          r1_q       <= e;
          t0_q       <= '0;
          t1_q       <= {{(TWIDTH-1){1'b0}}, 1'b1};
          err_path_q <= (e == '0) || (phi < 32'd2);
        end
        StDivide: begin
          if (div_start) div_sent_q <= 1'b1;
        end
        StUpdate: begin
          r0_q       <= r1_q;
          r1_q       <= remainder;
          t0_q       <= t1_q;
          t1_q       <= t_next;
          div_sent_q <= 1'b0;
        end
        StFixup: begin
          if (err_path_q || (r0_q != 32'd1)) begin
            out_q <= '0;
            err_q <= 1'b1;
          end else begin
            out_q <= t0_q[TWIDTH-1] ? t0_plus_phi[WIDTH-1:0] : t0_q[WIDTH-1:0];
            err_q <= 1'b0;
          end
        end
        StFinished: begin
          if (!inv_ready) begin
            out_q <= '0;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse.sv
// Directed bench for mod_inverse: known inverses, error cases, reset and early-drop handshakes.
module tb_mod_inverse;
  import rsa_pkg::*;

  localparam int Bound = 48 * 36 + 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inv_ready;
  logic [31:0] phi, e, out;
  logic        inv_done, inv_err;

  int vectors = 0;
  int miscompares = 0;
  int div_starts = 0;
  int cycles;

  mod_inverse dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .inv_ready (inv_ready),
    .phi       (phi),
    .e         (e),
    .out       (out),
    .inv_done  (inv_done),
    .inv_err   (inv_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.div_start) div_starts++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_inv(input longint p, input longint ee);
    longint r0, r1, t0, t1, q, tmp;
    r0 = p; r1 = ee; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      q = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
    end
    if (t0 < 0) t0 = t0 + p;
    return t0[31:0];
  endfunction

  // Full request: raise inv_ready, wait for inv_done, check hold, drop and check clearing.
  // With drop_early, inv_ready falls (and inputs are scrambled) while the divider is busy.
  task automatic run(input string tag, input logic [31:0] p, input logic [31:0] ee,
                     input logic [31:0] exp_out, input logic exp_err, input bit drop_early);
    @(negedge clk);
    phi = p; e = ee; inv_ready = 1'b1;
    cycles = 0;
    if (drop_early) begin
      repeat (6) @(negedge clk);
      cycles = 6;
      chk({tag, "_in_divide"}, 64'(dut.state_q), 64'(StDivide));
      inv_ready = 1'b0;
      phi = 32'h1234_5678; e = 32'd3;
    end
    while (!inv_done && cycles < Bound) begin
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_done"}, 64'(inv_done), 64'd1);
    chk({tag, "_out"}, 64'(out), 64'(exp_out));
    chk({tag, "_err"}, 64'(inv_err), 64'(exp_err));
    if (!drop_early) begin
      @(negedge clk);
      chk({tag, "_held"}, 64'(inv_done), 64'd1);
      inv_ready = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_clr_done"}, 64'(inv_done), 64'd0);
    chk({tag, "_clr_out"}, 64'(out), 64'd0);
    chk({tag, "_clr_err"}, 64'(inv_err), 64'd0);
  endtask

  initial begin
    logic [31:0] big_exp;
    reset_n = 1'b0; inv_ready = 1'b0; phi = '0; e = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_done", 64'(inv_done), 64'd0);
    chk("rst_err", 64'(inv_err), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("wait_state", 64'(dut.state_q), 64'(StWait));

    run("rsa3120", 32'd3120, 32'd17, 32'd2753, 1'b0, 1'b0);
    run("nocoprime", 32'd60, 32'd6, 32'd0, 1'b1, 1'b0);
    div_starts = 0;
    run("e_zero", 32'd60, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("e_zero_nodiv", 64'(div_starts), 64'd0);
    run("e_gt_phi", 32'd40, 32'd43, 32'd27, 1'b0, 1'b0);
    run("e_one", 32'd60, 32'd1, 32'd1, 1'b0, 1'b0);

    big_exp = model_inv(longint'(32'hFFFF_FFFE), longint'(65537));
    run("big", 32'hFFFF_FFFE, 32'd65537, big_exp, 1'b0, 1'b0);
    chk("big_modcheck", (64'd65537 * 64'(big_exp)) % 64'hFFFF_FFFE, 64'd1);
    chk("big_latency", 64'(cycles <= Bound), 64'd1);

    // Reset asserted mid-division must clear everything combinationally.
    @(negedge clk);
    phi = 32'd3120; e = 32'd17; inv_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_in_divide", 64'(dut.state_q), 64'(StDivide));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 64'(dut.state_q), 64'(StReset));
    chk("mid_rst_out", 64'(out), 64'd0);
    chk("mid_rst_done", 64'(inv_done), 64'd0);
    chk("mid_rst_err", 64'(inv_err), 64'd0);
    chk("mid_rst_r0", 64'(dut.r0_q), 64'd0);
    inv_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run("after_rst", 32'd3120, 32'd17, 32'd2753, 1'b0, 1'b0);

    run("drop", 32'd3120, 32'd17, 32'd2753, 1'b0, 1'b1);
    chk("drop_wait", 64'(dut.state_q), 64'(StWait));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
